// File: rtl/uart_8250_init_ctrl_if.sv
// Wishbone classic bus bundle for the UART init controller.
// The master drives the request; the slave returns ack and read data.
interface uart_8250_init_ctrl_if;
  logic [31:0] ADR;
  logic [31:0] DAT_W;
  logic [31:0] DAT_R;
  logic        WE;
  logic [3:0]  SEL;
  logic        STB;
  logic        CYC;
  logic        ACK;

  modport master (
    output ADR, DAT_W, WE, SEL, STB, CYC,
    input  DAT_R, ACK
  );

  modport slave (
    input  ADR, DAT_W, WE, SEL, STB, CYC,
    output DAT_R, ACK
  );
endinterface

// File: rtl/uart_8250_init_ctrl.sv
// UART 8250 init controller: writes a fixed init sequence, then passes CPU through.
// Optional ACK timeout guarded by macro UART_INIT_TIMEOUT_EN.
module uart_8250_init_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter logic [7:0]  IER_VAL     = 8'h01,
  parameter logic [7:0]  START_DELAY = 8'd4,
  parameter logic [15:0] TIMEOUT     = 16'd255
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  uart_8250_init_ctrl_if.slave         S,
  uart_8250_init_ctrl_if.master        M,
  input  logic                         reinit,
  output logic                         init_done,
  output logic                         init_err
);

  typedef enum logic [1:0] {
    ST_DELAY,
    ST_REQ,
    ST_GAP,
    ST_PASS
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] dly_q, dly_d;
  logic       done_q, done_d;
  logic       pend_q, pend_d;

  logic [2:0] off;
  logic [7:0] val;
  logic       last_step;
  logic       dly_end;

`ifdef UART_INIT_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`else
  logic        unused_tmo;
  assign unused_tmo = ^TIMEOUT;
`endif

  assign last_step = (step_q == 3'd5);
  assign dly_end   = ({1'b0, dly_q} + 9'd1) >= {1'b0, START_DELAY};

  // Register offset and value written by each init step
  always_comb begin
    off = 3'd1;
    val = IER_VAL;
    unique case (step_q)
      3'd0: begin off = 3'd3; val = 8'h80;          end
      3'd1: begin off = 3'd0; val = DIVISOR[7:0];   end
      3'd2: begin off = 3'd1; val = DIVISOR[15:8];  end
      3'd3: begin off = 3'd3; val = LCR_VAL;        end
      3'd4: begin off = 3'd2; val = FCR_VAL;        end
      default: begin off = 3'd1; val = IER_VAL;     end
    endcase
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dly_d   = dly_q;
    done_d  = done_q;
    pend_d  = pend_q;
`ifdef UART_INIT_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_DELAY: begin
        pend_d = 1'b0;
        if (dly_end) begin
          state_d = ST_REQ;
          step_d  = 3'd0;
          dly_d   = 8'd0;
`ifdef UART_INIT_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      ST_REQ: begin
        if (M.ACK) begin
          state_d = ST_GAP;
        end
`ifdef UART_INIT_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TIMEOUT) begin
            state_d = ST_PASS;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        if (last_step) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
        end else begin
          state_d = ST_REQ;
          step_d  = step_q + 3'd1;
`ifdef UART_INIT_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end
      end
      ST_PASS: begin
        // never cut a CPU cycle: hold the request until CYC drops
        if (reinit || pend_q) begin
          if (S.CYC) begin
            pend_d = 1'b1;
          end else begin
            state_d = ST_DELAY;
            dly_d   = 8'd0;
            done_d  = 1'b0;
            pend_d  = 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      default: state_d = ST_DELAY;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_DELAY;
      step_q  <= 3'd0;
      dly_q   <= 8'd0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
      tmo_q   <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
`ifdef UART_INIT_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Bus mux: own writes in REQ, CPU pass-through in PASS, idle otherwise
  always_comb begin
    M.ADR   = 32'd0;
    M.DAT_W = 32'd0;
    M.WE    = 1'b0;
    M.SEL   = 4'd0;
    M.STB   = 1'b0;
    M.CYC   = 1'b0;
    S.ACK   = 1'b0;
    S.DAT_R = 32'd0;
    unique case (1'b1)
      (state_q == ST_PASS): begin
        M.ADR   = S.ADR;
        M.DAT_W = S.DAT_W;
        M.WE    = S.WE;
        M.SEL   = S.SEL;
        M.STB   = S.STB;
        M.CYC   = S.CYC;
        S.ACK   = M.ACK;
        S.DAT_R = M.DAT_R;
      end
      (state_q == ST_REQ): begin
        M.ADR   = BASE_ADDR + {29'd0, off};
        M.DAT_W = {24'd0, val};
        M.WE    = 1'b1;
        M.SEL   = 4'b0001;
        M.STB   = 1'b1;
        M.CYC   = 1'b1;
      end
      default: ;
    endcase
  end

  assign init_done = done_q;
`ifdef UART_INIT_TIMEOUT_EN
  assign init_err  = err_q;
`else
  assign init_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_8250_init_ctrl.sv
// Bench for uart_8250_init_ctrl: UART slave model, init table,
// random CPU pass-through traffic and multi-cycle corner sequences.
module tb_uart_8250_init_ctrl;
  localparam logic [31:0] BASE = 32'h1250_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reinit = 1'b0;
  logic init_done, init_err;

  uart_8250_init_ctrl_if s_bus();
  uart_8250_init_ctrl_if m_bus();

  uart_8250_init_ctrl #(.TIMEOUT(16'd8)) dut (
    .CLK_I     (clk),
    .RST_I     (rst_n),
    .S         (s_bus),
    .M         (m_bus),
    .reinit    (reinit),
    .init_done (init_done),
    .init_err  (init_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] off;
    logic [7:0] val;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  vec_t tbl[6];
  wr_t  wlog[$];
  logic [7:0] uregs [8] = '{default: 8'h00};
  logic [7:0] exp_regs [8];
  int lat = 0;
  int wcnt = 0;
  bit ack_en = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int early_ack = 0;
  int ack_mis = 0;

  // UART slave: ACK after 'lat' extra cycles, logs every write
  always @(posedge clk) begin
    if (m_bus.CYC && m_bus.STB && !m_bus.ACK && ack_en) begin
      if (wcnt >= lat) begin
        m_bus.ACK <= 1'b1;
        wcnt <= 0;
        if (m_bus.WE) begin
          wlog.push_back('{m_bus.ADR, m_bus.DAT_W, m_bus.SEL});
          uregs[m_bus.ADR[2:0]] <= m_bus.DAT_W[7:0];
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      m_bus.ACK <= 1'b0;
      wcnt <= 0;
    end
  end

  always_comb m_bus.DAT_R = {24'h0, uregs[m_bus.ADR[2:0]]};

  // CPU must never see an ACK before init; afterwards ACK/data follow the UART
  always @(negedge clk) begin
    if (rst_n && !init_done && s_bus.ACK)
      early_ack <= early_ack + 1;
    if (rst_n && init_done &&
        (s_bus.ACK !== m_bus.ACK ||
         (s_bus.ACK && s_bus.DAT_R !== m_bus.DAT_R)))
      ack_mis <= ack_mis + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output logic [31:0] rd, output bit ok);
    @(posedge clk);
    #1;
    s_bus.ADR = adr;
    s_bus.DAT_W = wd;
    s_bus.WE = we;
    s_bus.SEL = sel;
    s_bus.CYC = 1'b1;
    s_bus.STB = 1'b1;
    ok = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_bus.ACK) begin
        rd = s_bus.DAT_R;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_bus.CYC = 1'b0;
    s_bus.STB = 1'b0;
    s_bus.WE = 1'b0;
  endtask

  // Called early in cycle 0 of a (re)start; returns the done cycle index
  task automatic wait_done(input int lim, output int cyc, output int fs);
    cyc = 0;
    fs = -1;
    forever begin
      @(negedge clk);
      if (m_bus.STB && fs < 0) fs = cyc;
      if (init_done || cyc >= lim) break;
      cyc++;
    end
    chk("done_seen", 32'(init_done), 32'd1);
  endtask

  task automatic pulse_reinit();
    @(posedge clk);
    #1 reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
  endtask

  task automatic check_seq(input int base, input string tag);
    chk({tag, "_len"}, 32'(wlog.size()), 32'(base + 6));
    for (int i = 0; i < 6; i++) begin
      if (base + i < wlog.size()) begin
        chk({tag, "_adr"}, wlog[base+i].adr, BASE + 32'(tbl[i].off));
        chk({tag, "_dat"}, wlog[base+i].dat, {24'h0, tbl[i].val});
        chk({tag, "_sel"}, 32'(wlog[base+i].sel), 32'd1);
      end
    end
  endtask

  task automatic apply_model();
    for (int i = 0; i < 6; i++) exp_regs[tbl[i].off] = tbl[i].val;
  endtask

  initial begin
    int cyc, fs, n0, k;
    logic [31:0] rd;
    bit ok;

    tbl[0] = '{3'd3, 8'h80};
    tbl[1] = '{3'd0, 8'h1B};
    tbl[2] = '{3'd1, 8'h00};
    tbl[3] = '{3'd3, 8'h03};
    tbl[4] = '{3'd2, 8'h07};
    tbl[5] = '{3'd1, 8'h01};
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    s_bus.ADR = '0;
    s_bus.DAT_W = '0;
    s_bus.WE = 1'b0;
    s_bus.SEL = '0;
    s_bus.STB = 1'b0;
    s_bus.CYC = 1'b0;

    #3;
    chk("rst_cyc", 32'(m_bus.CYC), 0);
    chk("rst_stb", 32'(m_bus.STB), 0);
    chk("rst_we", 32'(m_bus.WE), 0);
    chk("rst_sel", 32'(m_bus.SEL), 0);
    chk("rst_adr", m_bus.ADR, 0);
    chk("rst_datw", m_bus.DAT_W, 0);
    chk("rst_sack", 32'(s_bus.ACK), 0);
    chk("rst_sdat", s_bus.DAT_R, 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_err", 32'(init_err), 0);

    // Power-up sequence with a CPU read posted during step 2
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      wait_done(60, cyc, fs);
      begin
        k = 0;
        while (wlog.size() < 2 && k < 100) begin
          @(negedge clk);
          k++;
        end
        chk("rd_at_step2", 32'(wlog.size()), 32'd2);
        cpu_xfer(1'b0, BASE + 32'd3, 32'h0, 4'b0001, rd, ok);
        chk("rd_ok", 32'(ok), 1);
        chk("rd_lcr", rd, 32'h03);
      end
    join
    chk("first_stb", 32'(fs), 32'd4);
    chk("done_cycle", 32'(cyc), 32'd22);
    chk("err_clean", 32'(init_err), 0);
    check_seq(0, "init");
    apply_model();

    // Random CPU traffic through the pass-through path
    for (int t = 0; t < 24; t++) begin
      logic        we;
      logic [2:0]  o;
      logic [7:0]  d;
      logic [3:0]  sl;
      lat = int'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      sl = 4'($urandom_range(1, 15));
      n0 = wlog.size();
      cpu_xfer(we, BASE + 32'(o), {24'h0, d}, sl, rd, ok);
      chk("pt_ok", 32'(ok), 1);
      if (we) begin
        exp_regs[o] = d;
        chk("pt_wlen", 32'(wlog.size()), 32'(n0 + 1));
        chk("pt_wadr", wlog[wlog.size()-1].adr, BASE + 32'(o));
        chk("pt_wdat", wlog[wlog.size()-1].dat, {24'h0, d});
        chk("pt_wsel", 32'(wlog[wlog.size()-1].sel), 32'(sl));
      end else begin
        chk("pt_rd", rd, {24'h0, exp_regs[o]});
      end
    end

    // reinit during a CPU write: write completes, restart after CYC falls
    lat = 3;
    n0 = wlog.size();
    fork
      cpu_xfer(1'b1, BASE + 32'd1, 32'h5A, 4'b0001, rd, ok);
      begin
        @(posedge clk);
        #1 reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
      end
    join
    chk("ri_wr_ok", 32'(ok), 1);
    chk("ri_wr_len", 32'(wlog.size()), 32'(n0 + 1));
    chk("ri_wr_adr", wlog[wlog.size()-1].adr, BASE + 32'd1);
    chk("ri_wr_dat", wlog[wlog.size()-1].dat, 32'h5A);
    exp_regs[1] = 8'h5A;
    @(negedge clk);
    chk("ri_hold", 32'(init_done), 1);
    @(negedge clk);
    chk("ri_drop", 32'(init_done), 0);
    lat = 0;
    fork
      wait_done(80, cyc, fs);
      begin
        repeat (8) @(posedge clk);
        #1 reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
      end
    join
    check_seq(n0 + 1, "ri");
    apply_model();
    repeat (20) @(negedge clk);
    chk("ri_no_latch", 32'(wlog.size()), 32'(n0 + 7));
    chk("ri_done", 32'(init_done), 1);

    // Reset during REQ of step 3
    n0 = wlog.size();
    pulse_reinit();
    k = 0;
    while (!(wlog.size() == n0 + 3 && m_bus.STB) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rs_step3", 32'(wlog.size()), 32'(n0 + 3));
    #2 rst_n = 1'b0;
    #1;
    chk("rs_cyc", 32'(m_bus.CYC), 0);
    chk("rs_stb", 32'(m_bus.STB), 0);
    chk("rs_we", 32'(m_bus.WE), 0);
    chk("rs_adr", m_bus.ADR, 0);
    chk("rs_datw", m_bus.DAT_W, 0);
    chk("rs_done", 32'(init_done), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done(60, cyc, fs);
    chk("rs_done_cyc", 32'(cyc), 32'd22);
    check_seq(n0 + 3, "rs");
    apply_model();

`ifdef UART_INIT_TIMEOUT_EN
    // Silent UART: time out on step 0, then pass-through still works
    n0 = wlog.size();
    ack_en = 1'b0;
    pulse_reinit();
    k = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (m_bus.STB) k++;
      if (init_done || cyc >= 60) break;
      cyc++;
    end
    chk("to_stb_cycles", 32'(k), 32'd8);
    chk("to_done_cyc", 32'(cyc), 32'd12);
    chk("to_err", 32'(init_err), 1);
    chk("to_done", 32'(init_done), 1);
    chk("to_nowr", 32'(wlog.size()), 32'(n0));
    ack_en = 1'b1;
    cpu_xfer(1'b0, BASE + 32'd3, 32'h0, 4'b0001, rd, ok);
    chk("to_pt_ok", 32'(ok), 1);
    chk("to_pt_rd", rd, {24'h0, exp_regs[3]});
    n0 = wlog.size();
    pulse_reinit();
    @(negedge clk);
    chk("to_err_clr", 32'(init_err), 0);
    wait_done(60, cyc, fs);
    chk("to_err_stay0", 32'(init_err), 0);
    check_seq(n0, "to");
`else
    chk("err_tied", 32'(init_err), 0);
`endif

    chk("no_early_ack", 32'(early_ack), 0);
    chk("ack_follow", 32'(ack_mis), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
